// File: rtl/keypoint_scan_ctrl.sv
// Raster scan controller for the DoG keypoint stage: primes the line buffer, walks
// each interior column, and commits filtered keypoints to per-scale keypoint SRAMs.
module keypoint_scan_ctrl #(
  parameter int IMG_ROWS   = 480,
  parameter int IMG_COLS   = 640,
  parameter int ROW_W      = 9,
  parameter int COL_W      = 10,
  parameter int MARGIN     = 1,
  parameter int PRIME_ROWS = 2,
  parameter int NUM_SCALES = 2,
  parameter int KP_DEPTH   = 2048,
  parameter int KP_AW      = 11
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [NUM_SCALES-1:0]                 scale_en,
  input  logic [NUM_SCALES-1:0]                 is_keypoint,
  input  logic [NUM_SCALES-1:0]                 valid_keypoint,
  output logic [ROW_W-1:0]                      row_addr,
  output logic                                  buffer_we,
  output logic [COL_W-1:0]                      current_col,
  output logic                                  busy,
  output logic                                  done,
  output logic [NUM_SCALES-1:0]                 kp_we,
  output logic [NUM_SCALES*KP_AW-1:0]           kp_addr,
  output logic [NUM_SCALES*(ROW_W+COL_W)-1:0]   kp_din,
  output logic [NUM_SCALES*(KP_AW+1)-1:0]       kp_count,
  output logic [NUM_SCALES-1:0]                 kp_overflow
);

  localparam int KW = ROW_W + COL_W;
  localparam int CW = KP_AW + 1;
  localparam logic [COL_W-1:0] FIRST_COL  = COL_W'(MARGIN);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(IMG_COLS - 1 - MARGIN);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(IMG_ROWS - 1);
  localparam logic [ROW_W-1:0] PRIME_LAST = ROW_W'(PRIME_ROWS - 1);
  localparam logic [CW-1:0]    DEPTH      = CW'(KP_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_SCAN, S_FILTER, S_UPDATE, S_BUFFER, S_DONE
  } state_t;

  state_t                           state_q, state_d;
  logic [ROW_W-1:0]                 row_q, row_d;
  logic [COL_W-1:0]                 col_q, col_d;
  logic [NUM_SCALES-1:0]            en_q, en_d;
  logic [NUM_SCALES-1:0]            hit_q, hit_d;
  logic [NUM_SCALES-1:0]            we_q, we_d;
  logic [NUM_SCALES-1:0]            ovf_q, ovf_d;
  logic [NUM_SCALES-1:0][KP_AW-1:0] addr_q, addr_d;
  logic [NUM_SCALES-1:0][KW-1:0]    din_q, din_d;
  logic [NUM_SCALES-1:0][CW-1:0]    cnt_q, cnt_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             bwe_q, bwe_d;
  logic [NUM_SCALES-1:0]            hit_s;
  logic                             last_col_s;
  logic [ROW_W-1:0]                 center_row_s;

  // Next-state, datapath and status decode; abort overrides every transition.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    en_d         = en_q;
    hit_d        = hit_q;
    we_d         = '0;
    ovf_d        = ovf_q;
    addr_d       = addr_q;
    din_d        = din_q;
    cnt_d        = cnt_q;
    hit_s        = is_keypoint & en_q;
    last_col_s   = (col_q == LAST_COL);
    center_row_s = row_q - ROW_W'(1);

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = FIRST_COL;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            en_d    = scale_en;
            cnt_d   = '0;
            ovf_d   = '0;
            state_d = S_PRIME;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PRIME: begin
          row_d = row_q + ROW_W'(1);
          if (row_q == PRIME_LAST) begin
            state_d = S_SCAN;
          end else begin
            state_d = S_PRIME;
          end
        end
        S_SCAN: begin
          if (hit_s != '0) begin
            hit_d   = hit_s;
            state_d = S_FILTER;
          end else if (last_col_s) begin
            state_d = S_UPDATE;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
        S_FILTER: begin
          // A full SRAM drops the keypoint and latches the overflow flag instead.
          for (int s = 0; s < NUM_SCALES; s++) begin
            if (hit_q[s] && valid_keypoint[s]) begin
              if (cnt_q[s] < DEPTH) begin
                we_d[s]   = 1'b1;
                addr_d[s] = cnt_q[s][KP_AW-1:0];
                din_d[s]  = {center_row_s, col_q};
                cnt_d[s]  = cnt_q[s] + CW'(1);
              end else begin
                ovf_d[s] = 1'b1;
              end
            end else begin
              we_d[s] = 1'b0;
            end
          end
          if (last_col_s) begin
            state_d = S_UPDATE;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = S_SCAN;
          end
        end
        S_UPDATE: begin
          col_d = FIRST_COL;
          if (row_q == LAST_ROW) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = S_BUFFER;
          end
        end
        S_BUFFER: state_d = S_SCAN;
        S_DONE: begin
          row_d   = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    bwe_d  = (state_d == S_PRIME) || (state_d == S_BUFFER);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= FIRST_COL;
      en_q    <= '0;
      hit_q   <= '0;
      we_q    <= '0;
      ovf_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      en_q    <= en_d;
      hit_q   <= hit_d;
      we_q    <= we_d;
      ovf_q   <= ovf_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bwe_q   <= bwe_d;
    end
  end

  assign row_addr    = row_q;
  assign current_col = col_q;
  assign buffer_we   = bwe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign kp_we       = we_q;
  assign kp_addr     = addr_q;
  assign kp_din      = din_q;
  assign kp_count    = cnt_q;
  assign kp_overflow = ovf_q;

endmodule

// File: tb/tb_keypoint_scan_ctrl.sv
// Directed bench for keypoint_scan_ctrl on a 6x8 image with a 4-entry keypoint SRAM per scale.
module tb_keypoint_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [1:0]  scale_en, is_keypoint, valid_keypoint;
  logic [8:0]  row_addr;
  logic        buffer_we, busy, done;
  logic [9:0]  current_col;
  logic [1:0]  kp_we, kp_overflow;
  logic [3:0]  kp_addr;
  logic [37:0] kp_din;
  logic [5:0]  kp_count;

  int checks = 0;
  int errors = 0;

  // Comparator model: a scale fires on row_addr == pat_row (centre row + 1) at masked columns.
  logic [8:0] pat_row0, pat_row1;
  logic       pat_all0, pat_all1;
  logic [7:0] pat_col0, pat_col1;

  assign is_keypoint[0] = (pat_all0 || (row_addr == pat_row0)) && pat_col0[current_col[2:0]];
  assign is_keypoint[1] = (pat_all1 || (row_addr == pat_row1)) && pat_col1[current_col[2:0]];

  int         n_bwe, n_done, done_cyc, idle_cyc, n_we, ovf_cyc;
  int         we_cyc [8];
  logic [1:0] we_val [8];
  logic [3:0] we_addr[8];
  logic [37:0] we_din[8];
  logic [8:0] snap_row[64];
  logic [9:0] snap_col[64];

  keypoint_scan_ctrl #(
    .IMG_ROWS(6), .IMG_COLS(8), .ROW_W(9), .COL_W(10), .MARGIN(1),
    .PRIME_ROWS(2), .NUM_SCALES(2), .KP_DEPTH(4), .KP_AW(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .scale_en(scale_en),
    .is_keypoint(is_keypoint), .valid_keypoint(valid_keypoint),
    .row_addr(row_addr), .buffer_we(buffer_we), .current_col(current_col),
    .busy(busy), .done(done), .kp_we(kp_we), .kp_addr(kp_addr), .kp_din(kp_din),
    .kp_count(kp_count), .kp_overflow(kp_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_pattern;
    pat_row0 = 9'd0; pat_row1 = 9'd0;
    pat_all0 = 1'b0; pat_all1 = 1'b0;
    pat_col0 = 8'd0; pat_col1 = 8'd0;
    valid_keypoint = 2'b00;
  endtask

  // Start a frame in cycle 0 and record activity cycle by cycle until busy drops.
  task automatic run_frame(input logic [1:0] en);
    n_bwe = 0; n_done = 0; done_cyc = -1; idle_cyc = -1; n_we = 0; ovf_cyc = -1;
    @(negedge clk);
    scale_en = en;
    start    = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k < 64) begin
        snap_row[k] = row_addr;
        snap_col[k] = current_col;
      end
      if (buffer_we) n_bwe++;
      if (done) begin n_done++; done_cyc = k; end
      if (kp_we != 2'b00) begin
        if (n_we < 8) begin
          we_cyc[n_we] = k; we_val[n_we] = kp_we;
          we_addr[n_we] = kp_addr; we_din[n_we] = kp_din;
        end
        n_we++;
      end
      if (kp_overflow[0] && (ovf_cyc < 0)) ovf_cyc = k;
      if (!busy) begin idle_cyc = k; break; end
    end
    checks++;
    if (idle_cyc < 0) begin
      errors++;
      $display("FAIL frame_timeout: busy still high after 200 cycles");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; scale_en = 2'b00;
    clear_pattern();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (row_addr !== 9'd0) begin errors++; $display("FAIL reset_row_addr got %0d exp 0", row_addr); end
    checks++;
    if (current_col !== 10'd1) begin errors++; $display("FAIL reset_current_col got %0d exp 1", current_col); end
    checks++;
    if ({busy, done, buffer_we} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {busy, done, buffer_we}); end
    checks++;
    if ({kp_we, kp_addr, kp_overflow} !== 8'd0) begin errors++; $display("FAIL reset_kp_ctrl got %h exp 0", {kp_we, kp_addr, kp_overflow}); end
    checks++;
    if ({kp_din, kp_count} !== 44'd0) begin errors++; $display("FAIL reset_kp_data got %h exp 0", {kp_din, kp_count}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_without_start busy got %b exp 0", busy); end
  endtask

  task automatic test_no_hits;
    clear_pattern();
    run_frame(2'b11);
    checks++;
    if ({snap_row[3], snap_col[3]} !== {9'd2, 10'd1}) begin errors++; $display("FAIL first_scan_pos got %0d/%0d exp 2/1", snap_row[3], snap_col[3]); end
    checks++;
    if (snap_col[8] !== 10'd6) begin errors++; $display("FAIL last_col got %0d exp 6", snap_col[8]); end
    checks++;
    if ({snap_row[10], snap_col[10]} !== {9'd3, 10'd1}) begin errors++; $display("FAIL buffer_pos got %0d/%0d exp 3/1", snap_row[10], snap_col[10]); end
    checks++;
    if (done_cyc != 34 || n_done != 1) begin errors++; $display("FAIL nohit_done cycle %0d count %0d exp 34/1", done_cyc, n_done); end
    checks++;
    if (idle_cyc != 35) begin errors++; $display("FAIL nohit_idle got %0d exp 35", idle_cyc); end
    checks++;
    if (n_bwe != 5) begin errors++; $display("FAIL nohit_buffer_we got %0d exp 5", n_bwe); end
    checks++;
    if (snap_row[35] !== 9'd0) begin errors++; $display("FAIL row_after_done got %0d exp 0", snap_row[35]); end
    checks++;
    if (n_we != 0 || kp_count !== 6'd0) begin errors++; $display("FAIL nohit_writes n_we %0d count %h exp 0/0", n_we, kp_count); end
  endtask

  task automatic test_single_hit;
    clear_pattern();
    pat_row1 = 9'd3; pat_col1 = 8'b0000_1000; valid_keypoint = 2'b10;
    run_frame(2'b11);
    checks++;
    if (n_we != 1 || we_val[0] !== 2'b10 || we_cyc[0] != 15) begin errors++; $display("FAIL single_we n %0d val %b cyc %0d exp 1/10/15", n_we, we_val[0], we_cyc[0]); end
    checks++;
    if (we_addr[0][3:2] !== 2'd0) begin errors++; $display("FAIL single_addr got %0d exp 0", we_addr[0][3:2]); end
    checks++;
    if (we_din[0][37:19] !== {9'd2, 10'd3}) begin errors++; $display("FAIL single_din got %h exp %h", we_din[0][37:19], {9'd2, 10'd3}); end
    checks++;
    if (done_cyc != 35) begin errors++; $display("FAIL single_done got %0d exp 35", done_cyc); end
    checks++;
    if (kp_count !== 6'b001_000) begin errors++; $display("FAIL single_count got %b exp 001000", kp_count); end
  endtask

  task automatic test_dual_hit;
    clear_pattern();
    pat_row0 = 9'd2; pat_row1 = 9'd2;
    pat_col0 = 8'b0001_0000; pat_col1 = 8'b0001_0000; valid_keypoint = 2'b01;
    run_frame(2'b11);
    checks++;
    if (n_we != 1 || we_val[0] !== 2'b01 || we_cyc[0] != 8) begin errors++; $display("FAIL dual_we n %0d val %b cyc %0d exp 1/01/8", n_we, we_val[0], we_cyc[0]); end
    checks++;
    if (we_din[0][18:0] !== {9'd1, 10'd4} || we_addr[0][1:0] !== 2'd0) begin errors++; $display("FAIL dual_entry din %h addr %0d exp %h/0", we_din[0][18:0], we_addr[0][1:0], {9'd1, 10'd4}); end
    checks++;
    if (kp_count !== 6'b000_001 || done_cyc != 35) begin errors++; $display("FAIL dual_count got %b done %0d exp 000001/35", kp_count, done_cyc); end
  endtask

  task automatic test_overflow;
    clear_pattern();
    pat_row0 = 9'd3; pat_col0 = 8'b0111_1110; valid_keypoint = 2'b01;
    run_frame(2'b11);
    checks++;
    if (n_we != 4) begin errors++; $display("FAIL ovf_writes got %0d exp 4", n_we); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (we_cyc[i] != 13 + 2 * i || we_addr[i][1:0] !== 2'(i) || we_din[i][18:0] !== {9'd2, 10'(i + 1)}) begin
        errors++;
        $display("FAIL ovf_entry%0d cyc %0d addr %0d din %h exp %0d/%0d/%h", i, we_cyc[i], we_addr[i][1:0], we_din[i][18:0], 13 + 2 * i, i, {9'd2, 10'(i + 1)});
      end
    end
    checks++;
    if (ovf_cyc != 21) begin errors++; $display("FAIL ovf_set_cycle got %0d exp 21", ovf_cyc); end
    checks++;
    if (kp_count !== 6'b000_100 || kp_overflow !== 2'b01) begin errors++; $display("FAIL ovf_final count %b ovf %b exp 000100/01", kp_count, kp_overflow); end
    checks++;
    if (done_cyc != 40) begin errors++; $display("FAIL ovf_done got %0d exp 40", done_cyc); end
  endtask

  task automatic test_scale_mask;
    clear_pattern();
    pat_all1 = 1'b1; pat_col1 = 8'hFF; valid_keypoint = 2'b11;
    run_frame(2'b01);
    checks++;
    if (done_cyc != 34 || idle_cyc != 35 || n_bwe != 5) begin errors++; $display("FAIL mask_timing done %0d idle %0d bwe %0d exp 34/35/5", done_cyc, idle_cyc, n_bwe); end
    checks++;
    if (n_we != 0 || kp_count !== 6'd0) begin errors++; $display("FAIL mask_writes n_we %0d count %b exp 0/000000", n_we, kp_count); end
  endtask

  task automatic test_abort;
    int seen_done;
    seen_done = 0;
    clear_pattern();
    pat_row0 = 9'd2; pat_col0 = 8'b0000_0100; valid_keypoint = 2'b01;
    @(negedge clk);
    scale_en = 2'b11;
    start    = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = (k == 10);
      abort = 1'b0;
      if (done) seen_done++;
      if (k == 22) begin
        checks++;
        if ({row_addr, current_col} !== {9'd4, 10'd3}) begin errors++; $display("FAIL pre_abort_pos got %0d/%0d exp 4/3", row_addr, current_col); end
        abort = 1'b1;
      end
      if (k == 23) begin
        checks++;
        if ({busy, row_addr, current_col, kp_we} !== {1'b0, 9'd0, 10'd1, 2'b00}) begin
          errors++;
          $display("FAIL abort_state busy %b row %0d col %0d we %b exp 0/0/1/00", busy, row_addr, current_col, kp_we);
        end
      end
    end
    checks++;
    if (seen_done != 0) begin errors++; $display("FAIL abort_done_pulses got %0d exp 0", seen_done); end
    checks++;
    if (kp_count !== 6'b000_001) begin errors++; $display("FAIL abort_count_retained got %b exp 000001", kp_count); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (kp_count !== 6'd0 || busy !== 1'b1) begin errors++; $display("FAIL restart count %b busy %b exp 000000/1", kp_count, busy); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL restart_abort busy got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_no_hits();
    test_single_hit();
    test_dual_hit();
    test_overflow();
    test_scale_mask();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypoint_scan_ctrl.md
Name: keypoint_scan_ctrl

Overview:
- Parametrised scan controller for the DoG keypoint stage.
- Walks the image row by row and column by column, drives the shared row address of the pyramid SRAMs and the line-buffer write strobe, and presents `current_col` to NUM_SCALES external detect/filter comparators.
- Writes each accepted keypoint into a per-scale keypoint SRAM.
- Beyond the fixed two-scale version, it adds: configurable image size and border margin, per-scale enable mask, per-scale saturating keypoint counters with sticky overflow, abort, and busy/done status.

Parameters:
- IMG_ROWS, 480, image height in rows
- IMG_COLS, 640, image width in columns
- ROW_W, 9, row address/field width
- COL_W, 10, column field width
- MARGIN, 1, border columns skipped on each side
- PRIME_ROWS, 2, line-buffer priming reads before first scan row
- NUM_SCALES, 2, number of DoG scale channels
- KP_DEPTH, 2048, keypoint SRAM entries per scale (power of 2)
- KP_AW, 11, log2(KP_DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin frame scan (sampled in IDLE only)
- abort  in  1  terminate scan, return to IDLE
- scale_en  in  NUM_SCALES  per-scale enable; sampled at start
- is_keypoint  in  NUM_SCALES  extremum flag for current_col, per scale
- valid_keypoint  in  NUM_SCALES  edge/contrast filter pass, per scale
- row_addr  out  ROW_W  shared SRAM row address
- buffer_we  out  1  line-buffer shift strobe
- current_col  out  COL_W  column under test
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at frame end
- kp_we  out  NUM_SCALES  keypoint SRAM write enables
- kp_addr  out  NUM_SCALES*KP_AW  write address, scale s at [s*KP_AW +: KP_AW]
- kp_din  out  NUM_SCALES*(ROW_W+COL_W)  {row, col}, scale s in slice s
- kp_count  out  NUM_SCALES*(KP_AW+1)  keypoints stored per scale
- kp_overflow  out  NUM_SCALES  sticky, keypoint dropped due to full SRAM

Behaviour:
- Reset values:
  - state IDLE
  - row_addr 0
  - current_col MARGIN
  - busy, done, buffer_we, kp_we, kp_din, kp_count, kp_overflow all 0
  - kp_addr 0
- States: IDLE, PRIME, SCAN, FILTER, UPDATE, BUFFER, DONE.
- IDLE:
  - On start, latch scale_en into en_q, clear kp_count and kp_overflow, go to PRIME.
  - start is ignored in every other state.
- PRIME: lasts PRIME_ROWS cycles. Each cycle buffer_we=1 and row_addr increments. Then go to SCAN.
- Centre row of the current window is row_addr-1. This is the row field written to kp_din.
- SCAN: hit = is_keypoint & en_q.
  - hit==0: if current_col==IMG_COLS-1-MARGIN go to UPDATE; else current_col increments.
  - hit!=0: latch hit into hit_q, hold current_col, go to FILTER.
- FILTER: for each scale s with hit_q[s] & valid_keypoint[s]:
  - If kp_count[s] < KP_DEPTH: next cycle kp_we[s]=1, kp_addr[s]=kp_count[s] low bits, kp_din[s]={row_addr-1, current_col}; kp_count[s] increments.
  - Else: no write, kp_overflow[s] set to 1.
  - Column then advances exactly as in SCAN (last column goes to UPDATE, otherwise current_col+1 and back to SCAN).
- kp_we is registered: write happens 1 cycle after FILTER; every kp_we pulse is exactly 1 cycle.
- UPDATE: current_col returns to MARGIN.
  - If row_addr==IMG_ROWS-1, go to DONE.
  - Else row_addr increments and go to BUFFER.
- BUFFER: buffer_we=1 for 1 cycle, then SCAN.
- DONE: done=1 for 1 cycle; row_addr returns to 0; go to IDLE.
- Abort (any non-IDLE state):
  - Next cycle state=IDLE, row_addr=0, current_col=MARGIN, kp_we=0.
  - done is not asserted.
  - kp_count and kp_overflow are retained until the next start.
- Abort has priority over all transitions. rst has priority over abort.
- Scales with en_q=0 never cause FILTER and never write.

Test Plan:
Bench parameters for all scenarios: IMG_ROWS=6, IMG_COLS=8, MARGIN=1, NUM_SCALES=2, KP_DEPTH=4, KP_AW=2.
1. No hits, start at cycle 0 -> PRIME in cycles 1-2; rows 1..4 each give SCAN cols 1..6; done pulses in cycle 34; busy low from cycle 35; exactly 5 buffer_we pulses; kp_count=0.
2. is_keypoint=2'b10 and valid_keypoint=2'b10 at row 2, col 3, scale_en=11 -> one FILTER cycle, then kp_we=2'b10 with kp_addr[1]=0 and kp_din[1]={2,3}; done in cycle 35; kp_count[1]=1.
3. Both scales hit at the same column, valid_keypoint=2'b01 -> kp_we=2'b01 only; kp_count={0,1}.
4. Six valid scale-0 hits in one frame -> writes at addresses 0..3 only; kp_count[0]=4; kp_overflow[0]=1 after the 5th hit; no kp_we for the 5th or 6th hit.
5. scale_en=2'b01 and scale-1-only hits on every column -> no FILTER cycles, timing identical to scenario 1, kp_count[1]=0.
6. abort during row 3 SCAN -> busy=0 next cycle, row_addr=0, no done pulse; start asserted during a scan is ignored; a new start restarts with counts cleared.
